// File: rtl/renode_axi_request_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 manager port among
// several request sources; one transaction outstanding at a time.
module renode_axi_request_arbiter #(
   parameter int NumRequesters      = 4,
   parameter int AddressWidth       = 32,
   parameter int DataWidth          = 32,
   parameter int TransactionIdWidth = 8
) (
   input  logic                                   aclk,
   input  logic                                   areset_n,
   input  logic [NumRequesters-1:0]               req_valid,
   output logic [NumRequesters-1:0]               req_ready,
   input  logic [NumRequesters-1:0]               req_write,
   input  logic [NumRequesters*AddressWidth-1:0]  req_addr,
   input  logic [NumRequesters*3-1:0]             req_size,
   input  logic [NumRequesters*DataWidth-1:0]     req_wdata,
   input  logic [NumRequesters*DataWidth/8-1:0]   req_wstrb,
   output logic [NumRequesters-1:0]               rsp_valid,
   output logic [DataWidth-1:0]                   rsp_rdata,
   output logic                                   rsp_error,
   output logic [TransactionIdWidth-1:0]          awid,
   output logic [AddressWidth-1:0]                awaddr,
   output logic [7:0]                             awlen,
   output logic [2:0]                             awsize,
   output logic [1:0]                             awburst,
   output logic                                   awlock,
   output logic [2:0]                             awprot,
   output logic                                   awvalid,
   input  logic                                   awready,
   output logic [DataWidth-1:0]                   wdata,
   output logic [DataWidth/8-1:0]                 wstrb,
   output logic                                   wlast,
   output logic                                   wvalid,
   input  logic                                   wready,
   input  logic [TransactionIdWidth-1:0]          bid,
   input  logic [1:0]                             bresp,
   input  logic                                   bvalid,
   output logic                                   bready,
   output logic [TransactionIdWidth-1:0]          arid,
   output logic [AddressWidth-1:0]                araddr,
   output logic [7:0]                             arlen,
   output logic [2:0]                             arsize,
   output logic [1:0]                             arburst,
   output logic                                   arlock,
   output logic [2:0]                             arprot,
   output logic                                   arvalid,
   input  logic                                   arready,
   input  logic [TransactionIdWidth-1:0]          rid,
   input  logic [DataWidth-1:0]                   rdata,
   input  logic [1:0]                             rresp,
   input  logic                                   rlast,
   input  logic                                   rvalid,
   output logic                                   rready
);

   localparam int StrobeWidth = DataWidth / 8;
   localparam int IdxW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

   typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_e;

   state_e                   state_q, state_d;
   logic [IdxW-1:0]          rr_q, rr_d;
   logic [IdxW-1:0]          idx_q, idx_d;
   logic                     write_q, write_d;
   logic [AddressWidth-1:0]  addr_q, addr_d;
   logic [2:0]               size_q, size_d;
   logic [DataWidth-1:0]     wdata_q, wdata_d;
   logic [StrobeWidth-1:0]   wstrb_q, wstrb_d;
   logic                     arvalid_q, arvalid_d;
   logic                     awvalid_q, awvalid_d;
   logic                     wvalid_q, wvalid_d;
   logic                     rready_q, rready_d;
   logic                     bready_q, bready_d;
   logic                     got_q, got_d;
   logic [DataWidth-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic                     rsp_error_q, rsp_error_d;

   logic [AddressWidth-1:0]  addr_a  [NumRequesters];
   logic [2:0]               size_a  [NumRequesters];
   logic [DataWidth-1:0]     wdata_a [NumRequesters];
   logic [StrobeWidth-1:0]   wstrb_a [NumRequesters];

   logic                     found;
   logic [IdxW-1:0]          win;
   logic [IdxW-1:0]          j;
   logic [IdxW-1:0]          rr_next;
   logic                     unused_rlast;

   assign unused_rlast = rlast;

   always_comb begin
      for (int i = 0; i < NumRequesters; i++) begin
         addr_a[i]  = req_addr[i*AddressWidth +: AddressWidth];
         size_a[i]  = req_size[i*3 +: 3];
         wdata_a[i] = req_wdata[i*DataWidth +: DataWidth];
         wstrb_a[i] = req_wstrb[i*StrobeWidth +: StrobeWidth];
      end
   end

   // First pending requester at or after the pointer, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = '0;
      j     = '0;
      for (int i = 0; i < NumRequesters; i++) begin
         j = IdxW'((int'(rr_q) + i) % NumRequesters);
         if (!found && req_valid[j]) begin
            found = 1'b1;
            win   = j;
         end
      end
      rr_next = (win == IdxW'(NumRequesters - 1)) ? '0 : win + 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      idx_d       = idx_q;
      write_d     = write_q;
      addr_d      = addr_q;
      size_d      = size_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      arvalid_d   = arvalid_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      rready_d    = rready_q;
      bready_d    = bready_q;
      got_d       = got_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_error_d = rsp_error_q;
      req_ready   = '0;
      rsp_valid   = '0;

      // Responses are taken whenever the ready is up, even mid-address.
      if (rready_q && rvalid) begin
         rready_d    = 1'b0;
         got_d       = 1'b1;
         rsp_rdata_d = rdata;
         rsp_error_d = rresp[1] || (rid != TransactionIdWidth'(idx_q));
      end
      if (bready_q && bvalid) begin
         bready_d    = 1'b0;
         got_d       = 1'b1;
         rsp_rdata_d = '0;
         rsp_error_d = bresp[1] || (bid != TransactionIdWidth'(idx_q));
      end

      unique case (state_q)
         IDLE: begin
            if (found) begin
               req_ready[win] = 1'b1;
               idx_d     = win;
               rr_d      = rr_next;
               write_d   = req_write[win];
               addr_d    = addr_a[win];
               size_d    = size_a[win];
               wdata_d   = wdata_a[win];
               wstrb_d   = wstrb_a[win];
               arvalid_d = !req_write[win];
               awvalid_d = req_write[win];
               wvalid_d  = req_write[win];
               rready_d  = !req_write[win];
               bready_d  = req_write[win];
               got_d     = 1'b0;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            arvalid_d = arvalid_q && !arready;
            awvalid_d = awvalid_q && !awready;
            wvalid_d  = wvalid_q && !wready;
            if (!arvalid_d && !awvalid_d && !wvalid_d) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (got_d) begin
               state_d = DONE;
            end
         end
         DONE: begin
            rsp_valid[idx_q] = 1'b1;
            got_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         idx_q       <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         size_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         arvalid_q   <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         rready_q    <= 1'b0;
         bready_q    <= 1'b0;
         got_q       <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         idx_q       <= idx_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         arvalid_q   <= arvalid_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         rready_q    <= rready_d;
         bready_q    <= bready_d;
         got_q       <= got_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;

   assign arid    = TransactionIdWidth'(idx_q);
   assign araddr  = addr_q;
   assign arlen   = 8'd0;
   assign arsize  = size_q;
   assign arburst = 2'b01;
   assign arlock  = 1'b0;
   assign arprot  = 3'b000;
   assign arvalid = arvalid_q;
   assign rready  = rready_q;

   assign awid    = TransactionIdWidth'(idx_q);
   assign awaddr  = addr_q;
   assign awlen   = 8'd0;
   assign awsize  = size_q;
   assign awburst = 2'b01;
   assign awlock  = 1'b0;
   assign awprot  = 3'b000;
   assign awvalid = awvalid_q;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = 1'b1;
   assign wvalid  = wvalid_q;
   assign bready  = bready_q;

endmodule
